sha3_result_collector: RTL
==========================

Name: sha3_result_collector

Overview:
- Sits directly downstream of the scanner control block and consumes its capture strobe, relative nonce, difficulty hash word and status flags.
- Converts each relative nonce into an absolute nonce and queues results in a small FIFO. The host drains the FIFO through a valid/pop handshake.
- Tracks per-scan progress: hashes evaluated, scan completion and result overflow.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16.
CNT_W, 32, width of the evaluated-hash counter (saturating).

Ports:
clk  in  1  clock, all logic on rising edge.
rstn  in  1  asynchronous, active-low reset.
start  in  1  scan start pulse, same cycle the scanner receives it.
nonce_base  in  32  block template nonce field presented with start.
capture  in  1  scanner result strobe (one cycle per hit).
cnonce  in  32  relative nonce from scanner, valid with capture.
cdiff  in  64  difficulty hash word, valid with capture.
awaiting  in  1  scanner busy flag (high from start until pipeline flushed).
evaluating  in  1  one pulse per hash evaluated by scanner.
pop  in  1  host consumes FIFO head.
clear_done  in  1  host acknowledges completed scan.
ovalid  out  1  FIFO non-empty, head valid.
ononce  out  32  absolute nonce of head entry.
odiff  out  64  difficulty word of head entry.
olevel  out  $clog2(DEPTH)+1  entries held.
ooverflow  out  1  sticky: a capture was dropped this scan.
oevaluated  out  CNT_W  hashes evaluated this scan, saturating.
obusy  out  1  state == s_scanning.
odone  out  1  state == s_done.

Behaviour:
- Reset (rstn low, async): state s_idle, FIFO empty, base 0, all outputs 0. Reset mid-scan discards everything. Deassertion is synchronised internally; the first active edge follows.
- States:
  - s_idle: on start, go to s_scanning.
  - s_scanning: on awaiting falling edge (registered previous value 1, current 0), go to s_done.
  - s_done: on start, go to s_scanning; on clear_done, go to s_idle.
  - start has priority over clear_done when both are asserted.
- On start, in any state:
  - latch nonce_base.
  - flush FIFO (olevel 0 next cycle).
  - clear ooverflow and oevaluated.
  - start asserted while in s_scanning restarts the scan.
- Capture is accepted only in s_scanning; it is ignored in s_idle and s_done.
- Stage 1 register: capture, cnonce + base (mod 2^32, wraps silently), cdiff.
- Stage 2: write into FIFO.
  - Capture at edge N gives ovalid high after edge N+2 when the FIFO was empty.
- FIFO full on a stage-2 write with no simultaneous pop: drop the entry and set ooverflow. It stays set until start or reset.
- Simultaneous write and pop:
  - when full: pop first, write accepted, level unchanged, no overflow.
  - when empty: no pop; write lands and ovalid rises.
- pop while empty is ignored. Head outputs update the cycle after pop and hold their value while not popped.
- A capture in the same cycle as start belongs to the old scan and is discarded by the flush.
- oevaluated increments on each evaluating pulse in s_scanning and saturates at 2^CNT_W-1.
- awaiting is sampled every cycle. A falling edge outside s_scanning is ignored.

Optional Feature:
- SHA3_RESULT_TIMESTAMP_EN defined:
  - a 32-bit free-running cycle counter, reset to 0 and cleared on start, is stored with each entry.
  - it is presented on an extra output port otimestamp (32 bits) alongside the head entry.
  - the value is the counter at stage-1 capture.
- Not defined: the port exists, is tied to 0, and no counter or storage is built.

Test Plan:
- Reset, start with nonce_base=0x1000, capture cnonce=5 cdiff=0x00000000_0000FFFF -> ovalid rises 2 cycles later, ononce=0x1005, odiff matches, olevel=1; pop -> ovalid 0.
- nonce_base=0xFFFF_FFF0, capture cnonce=0x20 -> ononce=0x0000_0010 (wrap).
- DEPTH=4, 5 captures without pop -> olevel=4, ooverflow=1, first four nonces preserved in order. Then a fifth capture with pop in the same stage-2 cycle when full -> accepted, level stays 4.
- 100 evaluating pulses then awaiting 1->0 -> oevaluated=100, odone=1, obusy=0. clear_done -> s_idle. A capture in s_idle is ignored.
- Mid-scan: 2 entries queued, rstn low for 1 cycle asynchronously -> all outputs 0 immediately. Separately, start mid-scan -> FIFO flushed, ooverflow 0, new base used.
- With SHA3_RESULT_TIMESTAMP_EN: capture 10 cycles after start -> otimestamp=10 (±pipeline constant, fixed at 10 by design). Without the macro -> otimestamp stays 0.

Source files
------------

// File: rtl/sha3_result_collector.sv
// Result collector behind the SHA3 scanner: absolute-nonce conversion, result FIFO, scan progress.
// Optional macro SHA3_RESULT_TIMESTAMP_EN stores a per-entry cycle timestamp on otimestamp.
module sha3_result_collector #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 32
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     start,
   input  logic [31:0]              nonce_base,
   input  logic                     capture,
   input  logic [31:0]              cnonce,
   input  logic [63:0]              cdiff,
   input  logic                     awaiting,
   input  logic                     evaluating,
   input  logic                     pop,
   input  logic                     clear_done,
   output logic                     ovalid,
   output logic [31:0]              ononce,
   output logic [63:0]              odiff,
   output logic [$clog2(DEPTH):0]   olevel,
   output logic                     ooverflow,
   output logic [CNT_W-1:0]         oevaluated,
   output logic                     obusy,
   output logic                     odone,
   output logic [31:0]              otimestamp
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_SCANNING, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [1:0]       rst_sync;
   logic             rst_n_int;
   logic             awaiting_q;
   logic [31:0]      base_q;
   logic             s1_v, s2_v;
   logic [31:0]      s1_nonce, s2_nonce;
   logic [63:0]      s1_diff, s2_diff;
   logic [31:0]      mem_nonce [DEPTH];
   logic [63:0]      mem_diff  [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             ovf_q;
   logic [CNT_W-1:0] eval_q;
   logic             scanning, full, do_pop, do_wr, drop;

   // Assertion is immediate; release reaches the core two edges later.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) rst_sync <= '0;
      else       rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n_int = rst_sync[1];

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_q    <= S_IDLE;
         awaiting_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         awaiting_q <= awaiting;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (start) state_d = S_SCANNING;
         S_SCANNING: if (!start && awaiting_q && !awaiting) state_d = S_DONE;
         S_DONE: begin
            if (start)           state_d = S_SCANNING;
            else if (clear_done) state_d = S_IDLE;
         end
         default:    state_d = S_IDLE;
      endcase
   end

   assign scanning = (state_q == S_SCANNING);
   assign full     = (count == FULL);
   assign do_pop   = pop && (count != '0);
   assign do_wr    = s2_v && (!full || do_pop);
   assign drop     = s2_v && full && !do_pop;

   // A start flushes both pipeline stages so in-flight hits of the old scan never land.
   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         base_q   <= '0;
         s1_v     <= 1'b0;
         s1_nonce <= '0;
         s1_diff  <= '0;
         s2_v     <= 1'b0;
         s2_nonce <= '0;
         s2_diff  <= '0;
      end else begin
         if (start) base_q <= nonce_base;
         s1_v <= capture && scanning && !start;
         if (capture) begin
            s1_nonce <= cnonce + base_q;
            s1_diff  <= cdiff;
         end
         s2_v     <= s1_v && !start;
         s2_nonce <= s1_nonce;
         s2_diff  <= s1_diff;
      end
   end

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf_q  <= 1'b0;
      end else if (start) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (do_wr)  wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_wr) - (AW+1)'(do_pop);
         if (drop) ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_nonce[i] <= '0;
            mem_diff[i]  <= '0;
         end
      end else if (do_wr && !start) begin
         mem_nonce[wr_ptr] <= s2_nonce;
         mem_diff[wr_ptr]  <= s2_diff;
      end
   end

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int)                           eval_q <= '0;
      else if (start)                           eval_q <= '0;
      else if (evaluating && scanning && eval_q != '1) eval_q <= eval_q + CNT_W'(1);
   end

`ifdef SHA3_RESULT_TIMESTAMP_EN
   logic [31:0] ts_cnt, s1_ts, s2_ts;
   logic [31:0] mem_ts [DEPTH];

   // Stamp is the value the counter takes at the capture edge (edges since start).
   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         ts_cnt <= '0;
         s1_ts  <= '0;
         s2_ts  <= '0;
      end else begin
         ts_cnt <= start ? '0 : ts_cnt + 32'd1;
         if (capture) s1_ts <= ts_cnt + 32'd1;
         s2_ts <= s1_ts;
      end
   end

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_ts[i] <= '0;
      end else if (do_wr && !start) begin
         mem_ts[wr_ptr] <= s2_ts;
      end
   end

   assign otimestamp = mem_ts[rd_ptr];
`else
   assign otimestamp = '0;
`endif

   assign ovalid     = (count != '0);
   assign ononce     = mem_nonce[rd_ptr];
   assign odiff      = mem_diff[rd_ptr];
   assign olevel     = count;
   assign ooverflow  = ovf_q;
   assign oevaluated = eval_q;
   assign obusy      = (state_q == S_SCANNING);
   assign odone      = (state_q == S_DONE);

endmodule
